// File: rtl/n_bit_one_to_two_demux_reg.sv
// Registered 1-to-2 stream demultiplexer.
// Routes N-bit beats from one valid/ready/last input stream to output A or B.
// The route is sampled on the first beat of a packet and held until the last beat.
// Each side has one output register and a completed-packet counter.
// Optional feature: define DEMUX_BROADCAST_EN to add in_bcast. When set on the
// first beat, every beat of that packet goes to both sides.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | between packets; next beat's target comes from in_sel
// PKT_A    | mid-packet, locked to side A
// PKT_B    | mid-packet, locked to side B
// PKT_BOTH | mid-packet, locked to both sides (broadcast builds only)
module n_bit_one_to_two_demux_reg #(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic             in_last,
`ifdef DEMUX_BROADCAST_EN
  input  logic             in_bcast,
`endif
  output logic             in_ready,
  output logic [N-1:0]     a_data,
  output logic             a_valid,
  output logic             a_last,
  input  logic             a_ready,
  output logic [N-1:0]     b_data,
  output logic             b_valid,
  output logic             b_last,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PKT_A,
    PKT_B
`ifdef DEMUX_BROADCAST_EN
    , PKT_BOTH
`endif
  } state_t;

  state_t state, state_nxt;
  logic   tgt_a, tgt_b;
  logic   accept;
  logic   load_a, load_b;
  logic   bcast;

`ifdef DEMUX_BROADCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // State register; reset drops any packet lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Target selection, input ready and next-state logic.
  // Ready only looks at the targeted side(s), never at in_valid.
  always_comb begin
    tgt_a     = 1'b0;
    tgt_b     = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        tgt_a = !in_sel || bcast;
        tgt_b = in_sel || bcast;
      end
      PKT_A: tgt_a = 1'b1;
      PKT_B: tgt_b = 1'b1;
`ifdef DEMUX_BROADCAST_EN
      PKT_BOTH: begin
        tgt_a = 1'b1;
        tgt_b = 1'b1;
      end
`endif
      default: ;
    endcase

    in_ready = (!tgt_a || !a_valid || a_ready) && (!tgt_b || !b_valid || b_ready);
    accept   = in_valid && in_ready;
    load_a   = accept && tgt_a;
    load_b   = accept && tgt_b;

    if (accept) begin
      if (in_last) begin
        state_nxt = IDLE;
      end else if (state == IDLE) begin
`ifdef DEMUX_BROADCAST_EN
        if (bcast)       state_nxt = PKT_BOTH;
        else if (in_sel) state_nxt = PKT_B;
        else             state_nxt = PKT_A;
`else
        state_nxt = in_sel ? PKT_B : PKT_A;
`endif
      end
    end
  end

  // Side A output register: a load wins over a drain, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_last  <= 1'b0;
    end else if (load_a) begin
      a_valid <= 1'b1;
      a_data  <= in_data;
      a_last  <= in_last;
    end else if (a_valid && a_ready) begin
      a_valid <= 1'b0;
    end
  end

  // Side B output register, same behaviour as side A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_last  <= 1'b0;
    end else if (load_b) begin
      b_valid <= 1'b1;
      b_data  <= in_data;
      b_last  <= in_last;
    end else if (b_valid && b_ready) begin
      b_valid <= 1'b0;
    end
  end

  // Completed-packet counters, counted when the last beat leaves each side; wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      b_cnt <= '0;
    end else begin
      if (a_valid && a_ready && a_last) a_cnt <= a_cnt + CNT_W'(1);
      if (b_valid && b_ready && b_last) b_cnt <= b_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_n_bit_one_to_two_demux_reg.sv
// Bench for n_bit_one_to_two_demux_reg: directed scenarios plus random traffic,
// all checked against a queue-based reference model of the demux.
module tb_n_bit_one_to_two_demux_reg;
  localparam int N     = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     in_data;
  logic             in_valid, in_sel, in_last, in_ready;
  logic             in_bcast;
  logic [N-1:0]     a_data, b_data;
  logic             a_valid, a_last, a_ready;
  logic             b_valid, b_last, b_ready;
  logic [CNT_W-1:0] a_cnt, b_cnt;

  n_bit_one_to_two_demux_reg #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel), .in_last(in_last),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .a_cnt(a_cnt), .b_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each side is a one-slot FIFO of {last,data};
  // mode 0 = between packets, 1 = A, 2 = B, 3 = both.
  logic [N:0] qa[$];
  logic [N:0] qb[$];
  logic [N:0] hold_a, hold_b;
  int         cnt_a, cnt_b, mode;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    hold_a = '0;
    hold_b = '0;
    cnt_a  = 0;
    cnt_b  = 0;
    mode   = 0;
  endtask

  task automatic cycle(input logic v, input logic [N-1:0] d, input logic s, input logic l,
                       input logic bc, input logic ar, input logic br);
    logic ta, tb, rdy;
    @(posedge clk);
    #1;
    in_valid = v; in_data = d; in_sel = s; in_last = l; in_bcast = bc;
    a_ready = ar; b_ready = br;
    @(negedge clk);
    ta  = (mode == 1) || (mode == 3) || (mode == 0 && (bc || !s));
    tb  = (mode == 2) || (mode == 3) || (mode == 0 && (bc || s));
    rdy = (!ta || qa.size() == 0 || ar) && (!tb || qb.size() == 0 || br);
    check("in_ready", in_ready, rdy);
    check("a_valid", a_valid, qa.size() != 0);
    check("b_valid", b_valid, qb.size() != 0);
    check("a_beat", {a_last, a_data}, (qa.size() != 0) ? qa[0] : hold_a);
    check("b_beat", {b_last, b_data}, (qb.size() != 0) ? qb[0] : hold_b);
    check("a_cnt", a_cnt, cnt_a);
    check("b_cnt", b_cnt, cnt_b);
    if (qa.size() != 0 && ar) begin
      if (qa[0][N]) cnt_a = (cnt_a + 1) % (1 << CNT_W);
      void'(qa.pop_front());
    end
    if (qb.size() != 0 && br) begin
      if (qb[0][N]) cnt_b = (cnt_b + 1) % (1 << CNT_W);
      void'(qb.pop_front());
    end
    if (v && rdy) begin
      if (ta) begin qa.push_back({l, d}); hold_a = {l, d}; end
      if (tb) begin qb.push_back({l, d}); hold_b = {l, d}; end
      if (l)              mode = 0;
      else if (mode == 0) mode = bc ? 3 : (s ? 2 : 1);
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_a_beat", {a_last, a_data}, '0);
    check("rst_b_beat", {b_last, b_data}, '0);
    check("rst_cnts", {a_cnt, b_cnt}, '0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic bc_r;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_last = 1'b0; in_bcast = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    check("rst_idle_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // single-beat A packet
    cycle(1, 5'b01010, 0, 1, 0, 1, 0);
    cycle(0, 5'b00000, 0, 0, 0, 1, 0);
    cycle(0, 5'b00000, 0, 0, 0, 1, 0);

    // 3-beat B packet, sel toggles mid-packet
    cycle(1, 5'b10101, 1, 0, 0, 0, 1);
    cycle(1, 5'b00111, 0, 0, 0, 0, 1);
    cycle(1, 5'b11000, 0, 1, 0, 0, 1);
    cycle(0, 5'b00000, 0, 0, 0, 0, 1);
    cycle(0, 5'b00000, 0, 0, 0, 0, 1);

    // backpressure on B
    cycle(1, 5'b00001, 1, 0, 0, 0, 0);
    cycle(1, 5'b00010, 1, 0, 0, 0, 0);
    cycle(1, 5'b00010, 1, 0, 0, 0, 0);
    cycle(1, 5'b00010, 1, 0, 0, 0, 1);
    cycle(1, 5'b00011, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 5'b0, 0, 0, 0, 0, 1);

    // back-to-back A beats
    for (int i = 0; i < 8; i++) cycle(1, 5'(i + 3), 0, (i == 7), 0, 1, 0);
    cycle(0, 5'b0, 0, 0, 0, 1, 0);

    // async reset mid-packet, then route to B
    cycle(1, 5'b01111, 0, 0, 0, 0, 0);
    cycle(1, 5'b10000, 0, 0, 0, 0, 0);
    async_reset();
    for (int i = 0; i < 2; i++) cycle(0, 5'b0, 0, 0, 0, 1, 1);
    cycle(1, 5'b11100, 1, 1, 0, 1, 1);
    cycle(0, 5'b0, 0, 0, 0, 1, 1);
    cycle(0, 5'b0, 0, 0, 0, 1, 1);

    // counter wrap on A
    for (int i = 0; i < 10; i++) cycle(1, 5'(i), 0, 1, 0, 1, 1);
    cycle(0, 5'b0, 0, 0, 0, 1, 1);
    cycle(0, 5'b0, 0, 0, 0, 1, 1);

`ifdef DEMUX_BROADCAST_EN
    // broadcast 2-beat packet with B stalled
    cycle(1, 5'b10011, 0, 0, 1, 1, 0);
    cycle(1, 5'b01100, 0, 1, 0, 1, 0);
    cycle(1, 5'b01100, 0, 1, 0, 1, 0);
    cycle(1, 5'b01100, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 5'b0, 0, 0, 0, 1, 1);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
`ifdef DEMUX_BROADCAST_EN
      bc_r = ($urandom_range(0, 3) == 0);
`else
      bc_r = 1'b0;
`endif
      cycle(($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
            bc_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      if (i == 1500) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
